univ_shift_reg: RTL and testbench
=================================

Name: univ_shift_reg

Overview:
- Parametrised successor to the team's single-bit SISO shift register.
- WIDTH-bit universal shift register:
  - modes: hold, shift right, shift left, parallel load;
  - serial in/out at both ends and a full parallel output, so it covers SISO, SIPO, PISO and PIPO.
- A shift counter flags each completed word (WIDTH shifts), for use as a serialiser/deserialiser front end in the datapath.

Parameters:
- WIDTH, 8, register length in bits; legal range 2..64.
- CNT_W, derived (localparam) = $clog2(WIDTH); width of the shift counter. Not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  clock enable; 0 = hold all state.
- mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
- sin_r  input  1  serial in, enters at MSB on shift right.
- sin_l  input  1  serial in, enters at LSB on shift left.
- pdin  input  WIDTH  parallel load data.
- rot  input  1  rotate select; present only with ROTATE_EN.
- q  output  WIDTH  parallel register contents (PIPO/SIPO output).
- sout_r  output  1  q[0]; serial out for shift right.
- sout_l  output  1  q[WIDTH-1]; serial out for shift left.
- shift_cnt  output  CNT_W  shifts since last load/reset, modulo WIDTH.
- word_done  output  1  one-cycle pulse after the WIDTH-th shift.

Behaviour:
- Single clock domain; all state updates on rising clk. Outputs are driven from registers or direct register bits; no combinational path from inputs to outputs.

Reset:
- rst=1 at a clock edge sets q=0, shift_cnt=0, word_done=0.
- rst has priority over en and mode.
- Mid-operation reset discards the partial word; there is no recovery state.

Enable:
- en=0: q and shift_cnt hold; word_done=0 on the next edge.

Mode operations (with en=1):
- mode=00: q and shift_cnt hold; word_done=0.
- mode=01 (shift right): q <= {sin_r, q[WIDTH-1:1]}.
- mode=10 (shift left): q <= {q[WIDTH-2:0], sin_l}.
- mode=11 (load): q <= pdin; shift_cnt <= 0; word_done <= 0. A load also aborts any partial word.

Counter and word_done on each shift (mode 01 or 10, en=1):
- If shift_cnt == WIDTH-1: shift_cnt <= 0 and word_done <= 1.
- Otherwise: shift_cnt <= shift_cnt+1 and word_done <= 0.
- word_done is registered. It is high for exactly the cycle after the edge that performed the WIDTH-th shift. Back-to-back words give one pulse every WIDTH shifts.
- Direction may change between shifts; the counter counts shifts of either direction.
- Non-power-of-2 WIDTH: the counter wraps at WIDTH-1, not at 2^CNT_W-1.

Latency:
- SISO: a bit on sin_r appears on sout_r WIDTH edges later under continuous mode=01. Shift left is symmetric: sin_l to sout_l.
- PISO: after a load, sout_r = pdin[0] immediately; bit k appears after k shift edges.
- SIPO: q is valid in the cycle word_done=1.

Optional Feature:
- Macro: UNIV_SHIFT_REG_ROTATE_EN.
- Defined:
  - rot port exists.
  - In mode 01/10 with rot=1, the bit leaving the register is fed back instead of sin_r/sin_l: right rotate q <= {q[0], q[WIDTH-1:1]}; left rotate q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - Counter and word_done behave as for a normal shift.
  - rot is ignored in modes 00/11.
- Not defined: no rot port; shifts always take sin_r/sin_l. Behaviour is otherwise identical.

Test Plan (WIDTH=8):
- Reset: drive q nonzero via load 8'hA5; assert rst with en=1, mode=11, pdin=8'hFF -> next edge q=8'h00, shift_cnt=0, word_done=0.
- PISO: load 8'hB4, then 8 edges of mode=01, sin_r=0 -> sout_r sequence 0,0,1,0,1,1,0,1 (LSB first). word_done=1 exactly in the cycle after the 8th shift; q=8'h00; shift_cnt=0.
- SIPO/SISO: from reset, mode=10, sin_l stream 1,1,0,0,1,0,1,0 -> after 8 edges q=8'hCA and word_done pulses once. sout_l shows the first bit (1) in that same cycle.
- Enable/hold: mid-word after 3 shifts, hold 5 cycles (en=0, then en=1 with mode=00) -> q and shift_cnt=3 unchanged. The word then completes after 5 more shifts, not 8.
- Abort by load: after 6 shifts, mode=11 pdin=8'h3C -> q=8'h3C, shift_cnt=0, no word_done. The next word_done arrives only after 8 further shifts.
- With UNIV_SHIFT_REG_ROTATE_EN: load 8'h81, mode=01 rot=1 for 8 edges -> q returns to 8'h81 and word_done pulses once. After 1 edge q=8'hC0.

Source files
------------

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal shift register (hold / shift right / shift left / load) with a
// word counter that pulses word_done every WIDTH shifts. Optional rotate: UNIV_SHIFT_REG_ROTATE_EN.
module univ_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [1:0]                 mode,
    input  logic                       sin_r,
    input  logic                       sin_l,
    input  logic [WIDTH-1:0]           pdin,
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    input  logic                       rot,
`endif
    output logic [WIDTH-1:0]           q,
    output logic                       sout_r,
    output logic                       sout_l,
    output logic [$clog2(WIDTH)-1:0]   shift_cnt,
    output logic                       word_done
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;

    logic             w_in_r;
    logic             w_in_l;
    logic             w_cnt_last;
    logic [CNT_W-1:0] w_cnt_next;

    // Rotation feeds back the bit that is leaving the register.
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    assign w_in_r = rot ? r_q[0]       : sin_r;
    assign w_in_l = rot ? r_q[WIDTH-1] : sin_l;
`else
    assign w_in_r = sin_r;
    assign w_in_l = sin_l;
`endif

    // Explicit wrap so non-power-of-2 widths count 0..WIDTH-1.
    assign w_cnt_last = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_cnt_next = w_cnt_last ? '0 : r_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (!en) begin
            r_done <= 1'b0;
        end else begin
            case (mode)
                MODE_RIGHT: begin
                    r_q    <= {w_in_r, r_q[WIDTH-1:1]};
                    r_cnt  <= w_cnt_next;
                    r_done <= w_cnt_last;
                end
                MODE_LEFT: begin
                    r_q    <= {r_q[WIDTH-2:0], w_in_l};
                    r_cnt  <= w_cnt_next;
                    r_done <= w_cnt_last;
                end
                MODE_LOAD: begin
                    r_q    <= pdin;
                    r_cnt  <= '0;
                    r_done <= 1'b0;
                end
                MODE_HOLD: begin
                    r_done <= 1'b0;
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign q         = r_q;
    assign sout_r    = r_q[0];
    assign sout_l    = r_q[WIDTH-1];
    assign shift_cnt = r_cnt;
    assign word_done = r_done;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed-vector bench for univ_shift_reg at WIDTH=8; rotate test runs when
// UNIV_SHIFT_REG_ROTATE_EN is defined.
module tb_univ_shift_reg;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         en;
    logic [1:0]   mode;
    logic         sin_r;
    logic         sin_l;
    logic [W-1:0] pdin;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    logic         rot;
`endif
    logic [W-1:0] q;
    logic         sout_r;
    logic         sout_l;
    logic [2:0]   shift_cnt;
    logic         word_done;

    int total = 0;
    int bad   = 0;

    logic exp_q[$];

    univ_shift_reg #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .sin_r     (sin_r),
        .sin_l     (sin_l),
        .pdin      (pdin),
`ifdef UNIV_SHIFT_REG_ROTATE_EN
        .rot       (rot),
`endif
        .q         (q),
        .sout_r    (sout_r),
        .sout_l    (sout_l),
        .shift_cnt (shift_cnt),
        .word_done (word_done)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // driver tasks: inputs change and outputs are sampled 1 time unit after posedge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        en = 1'b1; mode = 2'b11; pdin = 8'hA5;
        tick();
        total++;
        if (q !== 8'hA5) begin bad++; $display("FAIL reset_preload_q: got %h expected a5", q); end
        rst = 1'b1; en = 1'b1; mode = 2'b11; pdin = 8'hFF;
        tick();
        rst = 1'b0;
        total++;
        if (q !== 8'h00) begin bad++; $display("FAIL reset_q: got %h expected 00", q); end
        total++;
        if (shift_cnt !== 3'd0) begin bad++; $display("FAIL reset_cnt: got %0d expected 0", shift_cnt); end
        total++;
        if (word_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", word_done); end
        mode = 2'b00;
    endtask

    task automatic test_piso();
        logic [W-1:0] val;
        val = 8'hB4;
        for (int i = 0; i < W; i++) exp_q.push_back(val[i]);
        en = 1'b1; mode = 2'b11; pdin = val;
        tick();
        mode = 2'b01; sin_r = 1'b0;
        for (int i = 0; i < W; i++) begin
            logic e;
            e = exp_q.pop_front();
            total++;
            if (sout_r !== e) begin bad++; $display("FAIL piso_sout_r[%0d]: got %b expected %b", i, sout_r, e); end
            total++;
            if (word_done !== 1'b0) begin bad++; $display("FAIL piso_early_done[%0d]: got %b expected 0", i, word_done); end
            tick();
        end
        total++;
        if (word_done !== 1'b1) begin bad++; $display("FAIL piso_done: got %b expected 1", word_done); end
        total++;
        if (q !== 8'h00) begin bad++; $display("FAIL piso_q: got %h expected 00", q); end
        total++;
        if (shift_cnt !== 3'd0) begin bad++; $display("FAIL piso_cnt: got %0d expected 0", shift_cnt); end
        mode = 2'b00;
        tick();
        total++;
        if (word_done !== 1'b0) begin bad++; $display("FAIL piso_done_pulse: got %b expected 0", word_done); end
    endtask

    task automatic test_sipo();
        logic [W-1:0] stream;
        int pulses;
        stream = 8'b1100_1010;
        pulses = 0;
        do_reset();
        en = 1'b1; mode = 2'b10;
        for (int i = 0; i < W; i++) begin
            sin_l = stream[W-1-i];
            tick();
            if (word_done === 1'b1) pulses++;
        end
        total++;
        if (q !== 8'hCA) begin bad++; $display("FAIL sipo_q: got %h expected ca", q); end
        total++;
        if (word_done !== 1'b1) begin bad++; $display("FAIL sipo_done: got %b expected 1", word_done); end
        total++;
        if (sout_l !== 1'b1) begin bad++; $display("FAIL sipo_sout_l: got %b expected 1", sout_l); end
        total++;
        if (pulses != 1) begin bad++; $display("FAIL sipo_pulses: got %0d expected 1", pulses); end
        mode = 2'b00;
        tick();
    endtask

    task automatic test_hold();
        do_reset();
        en = 1'b1; mode = 2'b10; sin_l = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 5; i++) begin
            en   = (i >= 3);
            mode = (i >= 3) ? 2'b00 : 2'b10;
            tick();
            total++;
            if (q !== 8'h07 || shift_cnt !== 3'd3) begin
                bad++; $display("FAIL hold[%0d]: got q=%h cnt=%0d expected q=07 cnt=3", i, q, shift_cnt);
            end
            total++;
            if (word_done !== 1'b0) begin bad++; $display("FAIL hold_done[%0d]: got %b expected 0", i, word_done); end
        end
        en = 1'b1; mode = 2'b10; sin_l = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (word_done !== (i == 4)) begin
                bad++; $display("FAIL hold_resume_done[%0d]: got %b expected %b", i, word_done, (i == 4));
            end
        end
        total++;
        if (q !== 8'hE0) begin bad++; $display("FAIL hold_resume_q: got %h expected e0", q); end
        mode = 2'b00;
        tick();
    endtask

    task automatic test_abort();
        do_reset();
        en = 1'b1; mode = 2'b01; sin_r = 1'b1;
        repeat (6) tick();
        total++;
        if (shift_cnt !== 3'd6) begin bad++; $display("FAIL abort_pre_cnt: got %0d expected 6", shift_cnt); end
        mode = 2'b11; pdin = 8'h3C;
        tick();
        total++;
        if (q !== 8'h3C || shift_cnt !== 3'd0 || word_done !== 1'b0) begin
            bad++; $display("FAIL abort_load: got q=%h cnt=%0d done=%b expected q=3c cnt=0 done=0", q, shift_cnt, word_done);
        end
        mode = 2'b01; sin_r = 1'b0;
        for (int i = 0; i < W; i++) begin
            tick();
            total++;
            if (word_done !== (i == W - 1)) begin
                bad++; $display("FAIL abort_done[%0d]: got %b expected %b", i, word_done, (i == W - 1));
            end
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 2 * W; i++) begin
            mode  = (i % 3 == 0) ? 2'b10 : 2'b01;
            sin_r = 1'b1; sin_l = 1'b0;
            tick();
            if (word_done === 1'b1) pulses++;
            total++;
            if (shift_cnt !== 3'((i + 1) % W)) begin
                bad++; $display("FAIL b2b_cnt[%0d]: got %0d expected %0d", i, shift_cnt, (i + 1) % W);
            end
            total++;
            if (word_done !== ((i + 1) % W == 0)) begin
                bad++; $display("FAIL b2b_done[%0d]: got %b expected %b", i, word_done, ((i + 1) % W == 0));
            end
        end
        total++;
        if (pulses != 2) begin bad++; $display("FAIL b2b_pulses: got %0d expected 2", pulses); end
        mode = 2'b00;
        tick();
    endtask

`ifdef UNIV_SHIFT_REG_ROTATE_EN
    task automatic test_rotate();
        int pulses;
        pulses = 0;
        do_reset();
        en = 1'b1; mode = 2'b11; pdin = 8'h81; rot = 1'b1;
        tick();
        mode = 2'b01; sin_r = 1'b0;
        tick();
        if (word_done === 1'b1) pulses++;
        total++;
        if (q !== 8'hC0) begin bad++; $display("FAIL rot_first: got %h expected c0", q); end
        repeat (W - 1) begin
            tick();
            if (word_done === 1'b1) pulses++;
        end
        total++;
        if (q !== 8'h81) begin bad++; $display("FAIL rot_q: got %h expected 81", q); end
        total++;
        if (word_done !== 1'b1 || pulses != 1) begin
            bad++; $display("FAIL rot_done: got done=%b pulses=%0d expected done=1 pulses=1", word_done, pulses);
        end
        rot = 1'b0; mode = 2'b00;
        tick();
    endtask
`endif

    initial begin
        rst = 1'b1; en = 1'b0; mode = 2'b00; sin_r = 1'b0; sin_l = 1'b0; pdin = '0;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
        rot = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
        test_reset();
        test_piso();
        test_sipo();
        test_hold();
        test_abort();
        test_back_to_back();
`ifdef UNIV_SHIFT_REG_ROTATE_EN
        test_rotate();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
